// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit for the single-cycle RV32I core.
// Evaluates RV32I branch conditions and handles JAL/JALR redirects, stall,
// halt/resume, trap entry and mret return. A three-state run-control FSM
// (BOOT -> RUN <-> HALT) gates fetch.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a jump/branch target with target[1:0] != 0 traps to
//               TRAP_VECTOR (epc = pc of the jump, misalign pulses).
//   undefined : target[1:0] is forced to 00 and misalign is tied low.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall               hold pc/epc/state (trap_req and mret still act)
//   halt_req, resume    enter / leave HALT
//   is_branch, is_jal, is_jalr, funct3, rs1_val, rs2_val, imm
//                       decoded control-flow info of the current instruction
//   trap_req, mret      trap entry / return
//   pc                  current fetch address
//   link_addr           pc + 4 (combinational)
//   epc                 saved pc of the trapping instruction
//   fetch_valid         pc is a valid fetch address (RUN state)
//   redirect            registered: last update was non-sequential
//   misalign            registered: last target was misaligned (feature only)
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            trap_req,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_addr,
  output logic [XLEN-1:0] epc,
  output logic            fetch_valid,
  output logic            redirect,
  output logic            misalign
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc_nx, epc_nx, jalr_sum, target;
  logic            redirect_nx, misalign_nx, taken, jump;

  assign link_addr = pc + XLEN'(4);
  assign jalr_sum  = rs1_val + imm;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // JALR wins over JAL/branch when several are set; both of the latter use pc+imm.
  assign jump   = is_jalr | is_jal | (is_branch & taken);
  assign target = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      epc      <= '0;
      redirect <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      epc      <= epc_nx;
      redirect <= redirect_nx;
      misalign <= misalign_nx;
    end
  end

  // Next-state logic. A stall that is not overridden by trap/mret also
  // holds the run state, so a halt request under stall waits.
  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = RUN;
      RUN:     if (halt_req && (trap_req || mret || !stall)) state_nx = HALT;
      HALT:    if (resume) state_nx = RUN;
      default: state_nx = BOOT;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    fetch_valid = (state == RUN);
    pc_nx       = pc;
    epc_nx      = epc;
    redirect_nx = 1'b0;
    misalign_nx = 1'b0;
    if (state == RUN) begin
      if (trap_req) begin
        pc_nx       = TRAP_VECTOR;
        epc_nx      = pc;
        redirect_nx = 1'b1;
      end else if (mret) begin
        pc_nx       = epc;
        redirect_nx = 1'b1;
      end else if (stall) begin
        pc_nx = pc;
      end else if (jump) begin
        redirect_nx = 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (target[1:0] != 2'b00) begin
          pc_nx       = TRAP_VECTOR;
          epc_nx      = pc;
          misalign_nx = 1'b1;
        end else begin
          pc_nx = target;
        end
`else
        pc_nx = target & ~XLEN'(3);
`endif
      end else begin
        pc_nx = link_addr;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with a behavioural reference model.
module tb_pc_sequencer;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h200;
  localparam logic [31:0] TV   = 32'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 0, halt_req = 0, resume = 0;
  logic        is_branch = 0, is_jal = 0, is_jalr = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] rs1_val = 0, rs2_val = 0, imm = 0;
  logic        trap_req = 0, mret = 0;
  logic [31:0] pc, link_addr, epc;
  logic        fetch_valid, redirect, misalign;

  pc_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .trap_req(trap_req), .mret(mret),
    .pc(pc), .link_addr(link_addr), .epc(epc), .fetch_valid(fetch_valid),
    .redirect(redirect), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = booting, 1 = running, 2 = halted
  logic [31:0] m_pc, m_epc;
  logic        m_red, m_mis;
  int          m_mode;

  function automatic bit cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] dest(input logic [31:0] cur);
    logic [31:0] s;
    if (is_jalr) begin
      s = rs1_val + imm;
      return s - (s % 2);
    end
    return cur + imm;
  endfunction

  function automatic bit jumping();
    return is_jalr || is_jal || (is_branch && cond(funct3, rs1_val, rs2_val));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc <= RV; m_epc <= 0; m_red <= 0; m_mis <= 0; m_mode <= 0;
    end else if (m_mode == 0) begin
      m_mode <= 1; m_red <= 0; m_mis <= 0;
    end else if (m_mode == 2) begin
      m_red <= 0; m_mis <= 0;
      if (resume) m_mode <= 1;
    end else begin
      m_red <= 0; m_mis <= 0;
      if (halt_req && (trap_req || mret || !stall)) m_mode <= 2;
      if (trap_req) begin
        m_pc <= TV; m_epc <= m_pc; m_red <= 1;
      end else if (mret) begin
        m_pc <= m_epc; m_red <= 1;
      end else if (stall) begin
        m_pc <= m_pc;
      end else if (jumping()) begin
        m_red <= 1;
`ifdef MISALIGN_TRAP_EN
        if (dest(m_pc) % 4 != 0) begin
          m_pc <= TV; m_epc <= m_pc; m_mis <= 1;
        end else m_pc <= dest(m_pc);
`else
        m_pc <= dest(m_pc) - (dest(m_pc) % 4);
`endif
      end else begin
        m_pc <= m_pc + 4;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("epc", epc, m_epc);
      chk("link_addr", link_addr, m_pc + 4);
      chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == 1));
      chk("redirect", 32'(redirect), 32'(m_red));
      chk("misalign", 32'(misalign), 32'(m_mis));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    stall = 0; halt_req = 0; resume = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 0; rs1_val = 0; rs2_val = 0; imm = 0; trap_req = 0; mret = 0;
  endtask

  task automatic setpc(input logic [31:0] v);
    clr(); is_jalr = 1; rs1_val = v; cyc(); clr();
  endtask

  initial begin
    // 1: reset and boot
    cyc(); chk_en = 1; cyc();
    chk("rst_pc", pc, 32'h200); chk("rst_fv", 32'(fetch_valid), 0);
    chk("rst_red", 32'(redirect), 0); chk("rst_epc", epc, 0);
    reset = 0; cyc();
    chk("boot_pc", pc, 32'h200); chk("boot_fv", 32'(fetch_valid), 1);
    cyc(); chk("seq1", pc, 32'h204);
    cyc(); chk("seq2", pc, 32'h208); chk("seq_red", 32'(redirect), 0);

    // 2: signed vs unsigned compare
    setpc(32'h40);
    is_branch = 1; funct3 = 3'b100; rs1_val = 32'hFFFF_FFFF; rs2_val = 1; imm = 32'hFFFF_FFF8;
    cyc(); chk("blt_pc", pc, 32'h38); chk("blt_red", 32'(redirect), 1);
    setpc(32'h40);
    is_branch = 1; funct3 = 3'b110; rs1_val = 32'hFFFF_FFFF; rs2_val = 1; imm = 32'hFFFF_FFF8;
    cyc(); chk("bltu_pc", pc, 32'h44); chk("bltu_red", 32'(redirect), 0);
    funct3 = 3'b001; rs2_val = 32'hFFFF_FFFF; imm = 32'h20;   // BNE equal: not taken
    cyc(); chk("bne_pc", pc, 32'h48);
    funct3 = 3'b101; rs2_val = 1;                              // BGE -1>=1: not taken
    cyc(); chk("bge_pc", pc, 32'h4C);
    funct3 = 3'b111;                                           // BGEU: taken
    cyc(); chk("bgeu_pc", pc, 32'h6C);
    funct3 = 3'b010; rs2_val = rs1_val;                        // reserved: never taken
    cyc(); chk("f010_pc", pc, 32'h70);

    // 3: JALR with odd sum
    setpc(32'h100);
    is_jalr = 1; rs1_val = 32'h1003;
    chk("jalr_link", link_addr, 32'h104);
    cyc();
`ifdef MISALIGN_TRAP_EN
    chk("jalr_pc", pc, 32'h100); chk("jalr_epc", epc, 32'h100); chk("jalr_mis", 32'(misalign), 1);
`else
    chk("jalr_pc", pc, 32'h1000); chk("jalr_mis", 32'(misalign), 0);
`endif
    chk("jalr_red", 32'(redirect), 1);
    setpc(32'h1000); is_jal = 1; imm = 6; cyc();
`ifdef MISALIGN_TRAP_EN
    chk("jal_mis_pc", pc, 32'h100);
`else
    chk("jal_mis_pc", pc, 32'h1004);
`endif

    // 4: stalled taken branch
    setpc(32'h80);
    is_branch = 1; funct3 = 0; rs1_val = 5; rs2_val = 5; imm = 32'h10; stall = 1;
    repeat (3) begin
      cyc(); chk("stall_pc", pc, 32'h80); chk("stall_red", 32'(redirect), 0);
    end
    stall = 0; cyc(); chk("unstall_pc", pc, 32'h90); chk("unstall_red", 32'(redirect), 1);

    // 5: trap beats jal, then mret; both beat stall
    setpc(32'h3C);
    trap_req = 1; is_jal = 1; imm = 32'h20;
    cyc(); chk("trap_pc", pc, 32'h100); chk("trap_epc", epc, 32'h3C); chk("trap_red", 32'(redirect), 1);
    clr(); mret = 1;
    cyc(); chk("mret_pc", pc, 32'h3C); chk("mret_red", 32'(redirect), 1);
    clr(); stall = 1; trap_req = 1;
    cyc(); chk("trap_stall_pc", pc, 32'h100);
    trap_req = 0; mret = 1;
    cyc(); chk("mret_stall_pc", pc, 32'h3C);
    clr(); is_jalr = 1; is_jal = 1; rs1_val = 32'h500; imm = 32'h10;
    cyc(); chk("prio_pc", pc, 32'h510);

    // 6: wrap-around, halt, resume
    setpc(32'hFFFF_FFFC);
    cyc(); chk("wrap_pc", pc, 32'h0); chk("wrap_red", 32'(redirect), 0);
    halt_req = 1; cyc(); chk("halt_pc", pc, 32'h4); chk("halt_fv", 32'(fetch_valid), 0);
    halt_req = 0; trap_req = 1;
    cyc(); chk("halt_trap_pc", pc, 32'h4); chk("halt_trap_red", 32'(redirect), 0);
    trap_req = 0; cyc(); chk("halt_hold", pc, 32'h4);
    resume = 1; cyc(); chk("resume_fv", 32'(fetch_valid), 1); chk("resume_pc", pc, 32'h4);
    resume = 0; cyc(); chk("resume_inc", pc, 32'h8);

    // halt requested under stall waits; reset mid-halt returns to boot
    stall = 1; halt_req = 1; cyc(); chk("stall_halt_fv", 32'(fetch_valid), 1);
    stall = 0; cyc(); chk("halted_fv", 32'(fetch_valid), 0);
    halt_req = 0; reset = 1; cyc(); chk("rst_halt_pc", pc, 32'h200); chk("rst_halt_epc", epc, 0);
    reset = 0; cyc(); chk("reboot_fv", 32'(fetch_valid), 1);
    stall = 1; cyc(); reset = 1; cyc(); chk("rst_stall_fv", 32'(fetch_valid), 0);
    reset = 0; stall = 0; cyc(); cyc(); chk("reboot2_pc", pc, 32'h204);

    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
